// File: rtl/stim_pkg.sv
// Shared types for the stimulus pattern sequencer: FSM states, table entry layout
// and the entry-count clamp used when a playback is accepted.
package stim_pkg;

  localparam int unsigned STIM_WIDTH  = 4;
  localparam int unsigned STIM_HOLD_W = 8;
  localparam int unsigned STIM_DEPTH  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  typedef struct packed {
    logic [STIM_WIDTH-1:0]  value;
    logic [STIM_HOLD_W-1:0] hold;
  } entry_t;

  // Requests beyond the table size play the whole table once.
  function automatic int unsigned clamp_entries(input int unsigned num,
                                                input int unsigned depth);
    return (num > depth) ? depth : num;
  endfunction

endpackage

// File: rtl/stim_table.sv
// DEPTH-entry (value, hold) register file: one synchronous write port, one
// combinational read port, contents cleared by the asynchronous reset.
module stim_table
  import stim_pkg::*;
#(
  parameter int unsigned DEPTH = STIM_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  entry_t                   wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output entry_t                   rd_data
);

  entry_t mem [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  // NOTE: the table is small and must read back as zero after reset, so it is
  // built from resettable flops rather than an inferred RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stim_pattern_seq.sv
// Programmable stimulus sequencer: plays a loaded table of (value, hold) entries
// onto sig_out cycle-accurately. Define STIM_LOOP_EN to add the 'loop' input.
module stim_pattern_seq
  import stim_pkg::*;
#(
  parameter int unsigned WIDTH  = STIM_WIDTH,
  parameter int unsigned DEPTH  = STIM_DEPTH,
  parameter int unsigned HOLD_W = STIM_HOLD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_value,
  input  logic [HOLD_W-1:0]        wr_hold,
  input  logic [$clog2(DEPTH):0]   num_entries,
  input  logic                     start,
  input  logic                     abort,
`ifdef STIM_LOOP_EN
  input  logic                     loop,
`endif
  output logic [WIDTH-1:0]         sig_out,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] cur_idx
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_d, last_q, last_d, rd_addr;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [WIDTH-1:0]   sig_d;
  logic               busy_d, done_d;
  logic [CNT_W-1:0]   num_clamped;
  logic               entry_done, last_entry, loop_en, tbl_wr_en;
  entry_t             rd_entry, wr_entry;

`ifdef STIM_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  assign num_clamped = CNT_W'(clamp_entries(32'(num_entries), DEPTH));
  assign entry_done  = (hold_q == '0);
  assign last_entry  = (cur_idx == last_q);

  // The table is frozen while playing so a pass always replays what was loaded.
  assign tbl_wr_en = wr_en && (state_q == IDLE);
  assign wr_entry  = '{value: wr_value, hold: wr_hold};

  // Single read port: entry 0 for a (re)start, otherwise the next entry.
  assign rd_addr = (state_q == PLAY && !last_entry) ? cur_idx + IDX_W'(1) : '0;

  stim_table #(.DEPTH(DEPTH)) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (tbl_wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_entry),
    .rd_addr (rd_addr),
    .rd_data (rd_entry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_idx <= '0;
      last_q  <= '0;
      hold_q  <= '0;
      sig_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_idx <= idx_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      sig_out <= sig_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!abort && start && num_clamped != '0) state_d = PLAY;
      PLAY: begin
        if (abort) state_d = IDLE;
        else if (entry_done && last_entry && !loop_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    idx_d  = cur_idx;
    last_d = last_q;
    hold_d = hold_q;
    sig_d  = sig_out;
    busy_d = busy;
    done_d = 1'b0;
    if (abort) begin
      idx_d  = '0;
      hold_d = '0;
      sig_d  = '0;
      busy_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (num_clamped == '0) begin
              done_d = 1'b1;
            end else begin
              idx_d  = '0;
              last_d = IDX_W'(num_clamped - CNT_W'(1));
              hold_d = rd_entry.hold;
              sig_d  = rd_entry.value;
              busy_d = 1'b1;
            end
          end
        end
        PLAY: begin
          if (!entry_done) begin
            hold_d = hold_q - HOLD_W'(1);
          end else if (!last_entry) begin
            idx_d  = cur_idx + IDX_W'(1);
            hold_d = rd_entry.hold;
            sig_d  = rd_entry.value;
          end else begin
            // End of pass: either wrap to entry 0 gaplessly or return to idle.
            done_d = 1'b1;
            idx_d  = '0;
            if (loop_en) begin
              hold_d = rd_entry.hold;
              sig_d  = rd_entry.value;
            end else begin
              hold_d = '0;
              sig_d  = '0;
              busy_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stim_pattern_seq.sv
// Self-checking bench for stim_pattern_seq: table-driven playback vectors plus
// hand-written abort, frozen-table, reset and loop sequences, scoreboard-checked.
module tb_stim_pattern_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_value = '0;
  logic [7:0] wr_hold = '0;
  logic [3:0] num_entries = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
`ifdef STIM_LOOP_EN
  logic       loop = 1'b0;
`endif
  logic [3:0] sig_out;
  logic       busy, done;
  logic [2:0] cur_idx;

  typedef struct packed {
    logic [3:0] sig;
    logic       busy;
    logic       done;
    logic [2:0] idx;
  } obs_t;

  typedef struct {
    string      name;
    logic [3:0] num;
    logic [3:0] val[8];
    logic [7:0] hold[8];
    int         exp_busy;
  } vec_t;

  obs_t sb[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;

  stim_pattern_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_value    (wr_value),
    .wr_hold     (wr_hold),
    .num_entries (num_entries),
    .start       (start),
    .abort       (abort),
`ifdef STIM_LOOP_EN
    .loop        (loop),
`endif
    .sig_out     (sig_out),
    .busy        (busy),
    .done        (done),
    .cur_idx     (cur_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic obs_t mk(input logic [3:0] s, input logic b, input logic d,
                              input logic [2:0] i);
    return {s, b, d, i};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge and compared
  // against the next scoreboard entry (idle zeros when nothing is expected).
  task automatic tick();
    obs_t act, exp;
    @(posedge clk);
    #1;
    act = {sig_out, busy, done, cur_idx};
    if (sb.size() != 0) exp = sb.pop_front();
    else exp = '0;
    if (busy) busy_cnt++;
    check($sformatf("out@%0t {sig,busy,done,idx}", $time), 32'(act), 32'(exp));
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (sb.size() != 0 && guard < 1000) begin
      tick();
      guard++;
    end
    check({name, " scoreboard drained"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic write_entry(input int addr, input logic [3:0] val, input logic [7:0] hold);
    wr_en    = 1'b1;
    wr_addr  = 3'(addr);
    wr_value = val;
    wr_hold  = hold;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic push_entry(input logic [3:0] val, input logic [7:0] hold, input int idx,
                            input logic first_done);
    for (int i = 0; i <= int'(hold); i++)
      sb.push_back(mk(val, 1'b1, (i == 0) ? first_done : 1'b0, 3'(idx)));
  endtask

  task automatic push_pass(input vec_t v);
    int n;
    n = (v.num > 4'd8) ? 8 : int'(v.num);
    for (int k = 0; k < n; k++) push_entry(v.val[k], v.hold[k], k, 1'b0);
    sb.push_back(mk(4'h0, 1'b0, 1'b1, 3'h0));
  endtask

  task automatic load_table(input vec_t v);
    for (int k = 0; k < 8; k++) write_entry(k, v.val[k], v.hold[k]);
  endtask

  task automatic pulse_start(input logic [3:0] num);
    num_entries = num;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    load_table(v);
    push_pass(v);
    busy_cnt = 0;
    pulse_start(v.num);
    drain(v.name);
    check({v.name, " busy cycles"}, busy_cnt, v.exp_busy);
    tick();
  endtask

  initial begin
    vecs[0] = '{name: "basic", num: 4'd3,
                val:  '{4'hF, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0},
                hold: '{8'd1, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, exp_busy: 6};
    vecs[1] = '{name: "empty", num: 4'd0,
                val:  '{4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7},
                hold: '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, exp_busy: 0};
    vecs[2] = '{name: "clamp", num: 4'd15,
                val:  '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8},
                hold: '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, exp_busy: 8};
    vecs[3] = '{name: "mixed", num: 4'd4,
                val:  '{4'hA, 4'h3, 4'hC, 4'h7, 4'h9, 4'h9, 4'h9, 4'h9},
                hold: '{8'd0, 8'd3, 8'd1, 8'd0, 8'd2, 8'd2, 8'd2, 8'd2}, exp_busy: 8};
    vecs[4] = '{name: "maxhold", num: 4'd1,
                val:  '{4'h6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0},
                hold: '{8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, exp_busy: 256};

    // Reset state, checked while reset is still asserted.
    #3;
    check("reset outputs", 32'({sig_out, busy, done, cur_idx}), 32'd0);
    #10 rst_n = 1'b1;
    tick();
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Abort during cycle 3 of a playback: outputs clear next cycle, no done.
    load_table(vecs[0]);
    push_entry(4'hF, 8'd1, 0, 1'b0);
    sb.push_back(mk(4'h5, 1'b1, 1'b0, 3'd1));
    pulse_start(4'd3);
    tick();
    tick();
    abort = 1'b1;
    sb.push_back(mk(4'h0, 1'b0, 1'b0, 3'd0));
    tick();
    abort = 1'b0;
    tick();
    tick();
    run_vec(vecs[0]);

    // Abort and start together: abort wins, nothing plays.
    abort = 1'b1;
    pulse_start(4'd3);
    abort = 1'b0;
    tick();
    tick();

    // Write and start while busy are both ignored; replay shows original table.
    push_pass(vecs[0]);
    pulse_start(4'd3);
    tick();
    wr_en    = 1'b1;
    wr_addr  = 3'd1;
    wr_value = 4'h9;
    wr_hold  = 8'd3;
    start    = 1'b1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    drain("busy write");
    tick();
    push_pass(vecs[0]);
    pulse_start(4'd3);
    drain("frozen replay");
    tick();

    // Asynchronous reset mid-playback clears outputs at once and the table.
    push_pass(vecs[0]);
    pulse_start(4'd3);
    tick();
    rst_n = 1'b0;
    #2;
    check("async reset outputs", 32'({sig_out, busy, done, cur_idx}), 32'd0);
    sb.delete();
    rst_n = 1'b1;
    sb.push_back(mk(4'h0, 1'b1, 1'b0, 3'd0));
    sb.push_back(mk(4'h0, 1'b0, 1'b1, 3'd0));
    pulse_start(4'd1);
    drain("cleared table");
    tick();

`ifdef STIM_LOOP_EN
    // Looping two hold-0 entries: gapless repeats, done once per wrap.
    write_entry(0, 4'hA, 8'd0);
    write_entry(1, 4'h5, 8'd0);
    loop = 1'b1;
    sb.push_back(mk(4'hA, 1'b1, 1'b0, 3'd0));
    sb.push_back(mk(4'h5, 1'b1, 1'b0, 3'd1));
    for (int p = 0; p < 2; p++) begin
      sb.push_back(mk(4'hA, 1'b1, 1'b1, 3'd0));
      sb.push_back(mk(4'h5, 1'b1, 1'b0, 3'd1));
    end
    sb.push_back(mk(4'h0, 1'b0, 1'b1, 3'd0));
    pulse_start(4'd2);
    for (int t = 0; t < 5; t++) tick();
    loop = 1'b0;
    drain("loop");
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
